// File: rtl/madgwick_pkg.sv
// Shared state type, default Q-formats and fixed-point helpers for the Madgwick filter datapath.
package madgwick_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAcc,
      StIsqReq,
      StIsqWait,
      StScale,
      StDone
   } vec_norm_state_t;

   localparam int unsigned DefDataWidth     = 16;
   localparam int unsigned DefFractWidth    = 12;
   localparam int unsigned DefIsqIntWidth   = 8;
   localparam int unsigned DefIsqFractWidth = 16;

   // Add half an output LSB at bit sh-1, then arithmetic shift right by sh.
   function automatic logic signed [63:0] round_shift_signed(input logic signed [63:0] v,
                                                             input int unsigned sh);
      logic signed [63:0] res;
      if (sh == 0) begin
         res = v;
      end else begin
         res = (v + (64'sd1 <<< (sh - 1))) >>> sh;
      end
      return res;
   endfunction

   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                     input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      logic signed [63:0] res;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) begin
         res = hi;
      end else if (v < lo) begin
         res = lo;
      end else begin
         res = v;
      end
      return res;
   endfunction

endpackage

// File: rtl/fastInvSqrt.sv
// Iterative inverse square root: bit-serial search for the largest y with y*y*x <= 1,
// one result bit per cycle, valid/ready on both sides.
module fastInvSqrt #(
   parameter int unsigned INT_WIDTH   = 8,
   parameter int unsigned FRACT_WIDTH = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             valid_in,
   output logic                             ready_in,
   input  logic [INT_WIDTH+FRACT_WIDTH-1:0] data_in,
   output logic                             valid_out,
   input  logic                             ready_out,
   output logic [INT_WIDTH+FRACT_WIDTH-1:0] data_out
);
   localparam int unsigned W     = INT_WIDTH + FRACT_WIDTH;
   localparam int unsigned W2    = 2 * W;
   localparam int unsigned W3    = 3 * W;
   localparam int unsigned BIT_W = $clog2(W);
   localparam logic [W3-1:0] One = W3'(1) << (3 * FRACT_WIDTH);

   typedef enum logic [1:0] {IsqIdle, IsqRun, IsqOut} isq_state_t;

   isq_state_t       state_q, state_d;
   logic [W-1:0]     x_q, x_d, y_q, y_d;
   logic [BIT_W-1:0] bit_q, bit_d;

   logic [W-1:0]  trial;
   logic [W2-1:0] trial_sq;
   logic [W3-1:0] trial_prod;
   logic          trial_ok;

   always_comb begin
      trial      = y_q | (W'(1) << bit_q);
      trial_sq   = W2'(trial) * W2'(trial);
      trial_prod = W3'(trial_sq) * W3'(x_q);
      trial_ok   = trial_prod <= One;
   end

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      bit_d     = bit_q;
      ready_in  = 1'b0;
      valid_out = 1'b0;
      case (state_q)
         IsqIdle: begin
            ready_in = 1'b1;
            if (valid_in) begin
               x_d     = data_in;
               y_d     = '0;
               // Sign bit of the result stays clear; search starts one below it.
               bit_d   = BIT_W'(W - 2);
               state_d = IsqRun;
            end
         end
         IsqRun: begin
            if (trial_ok) y_d = trial;
            if (bit_q == '0) state_d = IsqOut;
            else bit_d = bit_q - BIT_W'(1);
         end
         IsqOut: begin
            valid_out = 1'b1;
            if (ready_out) state_d = IsqIdle;
         end
         default: state_d = IsqIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IsqIdle;
         x_q     <= '0;
         y_q     <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         bit_q   <= bit_d;
      end
   end

   assign data_out = y_q;

endmodule

// File: rtl/vec_norm_seq.sv
// Sequential vector normaliser: sum of squares, inverse square root, then per-element scaling,
// all through one shared multiplier.
module vec_norm_seq
   import madgwick_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = DefDataWidth,
   parameter int unsigned FRACT_WIDTH     = DefFractWidth,
   parameter int unsigned NUM_CH          = 3,
   parameter int unsigned ISQ_INT_WIDTH   = DefIsqIntWidth,
   parameter int unsigned ISQ_FRACT_WIDTH = DefIsqFractWidth
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [DATA_WIDTH*NUM_CH-1:0] data_in,
   output logic                         busy,
   output logic                         done,
   output logic                         zero_err,
   output logic [DATA_WIDTH*NUM_CH-1:0] data_out
);
   localparam int unsigned VEC_W     = DATA_WIDTH * NUM_CH;
   localparam int unsigned ISQ_W     = ISQ_INT_WIDTH + ISQ_FRACT_WIDTH;
   localparam int unsigned PROD_W    = DATA_WIDTH + ISQ_W;
   localparam int unsigned ACC_W     = 2 * DATA_WIDTH + $clog2(NUM_CH);
   localparam int unsigned CNT_W     = $clog2(NUM_CH);
   localparam int unsigned ACC_SHIFT = 2 * FRACT_WIDTH - ISQ_FRACT_WIDTH;
   localparam logic [CNT_W-1:0]   CntLast = CNT_W'(NUM_CH - 1);
   localparam logic signed [63:0] IsqMax  = (64'sd1 <<< (ISQ_W - 1)) - 64'sd1;

   vec_norm_state_t  state_q, state_d;
   logic [VEC_W-1:0] vec_q, vec_d, stage_q, stage_d, data_out_q, data_out_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ISQ_W-1:0] r_q, r_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic             zero_err_q, zero_err_d, zero_q, zero_d;

   logic signed [DATA_WIDTH-1:0] x_sel;
   logic signed [ISQ_W-1:0]      mul_b;
   logic signed [PROD_W-1:0]     prod;
   logic signed [63:0]           isq_rnd;
   logic [ISQ_W-1:0]             isq_op;
   logic [DATA_WIDTH-1:0]        scaled;

   logic             isq_valid_in, isq_ready_in, isq_valid_out, isq_ready_out;
   logic [ISQ_W-1:0] isq_data_out;

   // Shared multiplier: x*x while accumulating, x*r while scaling.
   assign x_sel = vec_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];
   assign mul_b = (state_q == StScale) ? r_q
                                       : {{(ISQ_W - DATA_WIDTH){x_sel[DATA_WIDTH-1]}}, x_sel};
   assign prod  = x_sel * mul_b;

   always_comb begin
      isq_rnd = round_shift_signed(64'(acc_q), ACC_SHIFT);
      if (isq_rnd > IsqMax) isq_op = ISQ_W'(IsqMax);
      else if (isq_rnd == 64'sd0) isq_op = ISQ_W'(1);
      else isq_op = isq_rnd[ISQ_W-1:0];
      scaled = DATA_WIDTH'(sat_signed(round_shift_signed(64'(prod), ISQ_FRACT_WIDTH),
                                      DATA_WIDTH));
   end

   assign isq_valid_in  = (state_q == StIsqReq);
   assign isq_ready_out = (state_q == StIsqWait);

   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      stage_d    = stage_q;
      data_out_d = data_out_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      r_d        = r_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      zero_err_d = zero_err_q;
      zero_d     = zero_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               vec_d      = data_in;
               acc_d      = '0;
               cnt_d      = '0;
               busy_d     = 1'b1;
               zero_err_d = 1'b0;
               zero_d     = 1'b0;
               state_d    = StAcc;
            end
         end
         StAcc: begin
            acc_d = acc_q + ACC_W'(prod[2*DATA_WIDTH-1:0]);
            if (cnt_q == CntLast) begin
               cnt_d = '0;
               if (acc_d == '0) begin
                  stage_d = '0;
                  zero_d  = 1'b1;
                  state_d = StDone;
               end else begin
                  state_d = StIsqReq;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StIsqReq: begin
            if (isq_ready_in) state_d = StIsqWait;
         end
         StIsqWait: begin
            if (isq_valid_out) begin
               r_d     = isq_data_out;
               state_d = StScale;
            end
         end
         StScale: begin
            stage_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = scaled;
            if (cnt_q == CntLast) begin
               cnt_d   = '0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StDone: begin
            data_out_d = stage_q;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            zero_err_d = zero_q;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         vec_q      <= '0;
         stage_q    <= '0;
         data_out_q <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         r_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         zero_err_q <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         stage_q    <= stage_d;
         data_out_q <= data_out_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         r_q        <= r_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         zero_err_q <= zero_err_d;
         zero_q     <= zero_d;
      end
   end

   fastInvSqrt #(
      .INT_WIDTH  (ISQ_INT_WIDTH),
      .FRACT_WIDTH(ISQ_FRACT_WIDTH)
   ) u_isq (
      .clk      (clk),
      .rst_n    (~rst),
      .valid_in (isq_valid_in),
      .ready_in (isq_ready_in),
      .data_in  (isq_op),
      .valid_out(isq_valid_out),
      .ready_out(isq_ready_out),
      .data_out (isq_data_out)
   );

   assign busy     = busy_q;
   assign done     = done_q;
   assign zero_err = zero_err_q;
   assign data_out = data_out_q;

endmodule

// File: tb/tb_vec_norm_seq.sv
// Directed bench for vec_norm_seq with a 3-channel and a 4-channel instance sharing clock/reset.
module tb_vec_norm_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start3 = 1'b0;
   logic        start4 = 1'b0;
   logic [47:0] din3 = '0;
   logic [47:0] dout3;
   logic [63:0] din4 = '0;
   logic [63:0] dout4;
   logic        busy3, done3, zerr3, busy4, done4, zerr4;
   int          checks = 0;
   int          errors = 0;
   int          lat_l  = 24;

   always #5 clk = ~clk;

   vec_norm_seq #(
      .DATA_WIDTH(16), .FRACT_WIDTH(12), .NUM_CH(3), .ISQ_INT_WIDTH(8), .ISQ_FRACT_WIDTH(16)
   ) dut3 (
      .clk(clk), .rst(rst), .start(start3), .data_in(din3),
      .busy(busy3), .done(done3), .zero_err(zerr3), .data_out(dout3)
   );

   vec_norm_seq #(
      .DATA_WIDTH(16), .FRACT_WIDTH(12), .NUM_CH(4), .ISQ_INT_WIDTH(8), .ISQ_FRACT_WIDTH(16)
   ) dut4 (
      .clk(clk), .rst(rst), .start(start4), .data_in(din4),
      .busy(busy4), .done(done4), .zero_err(zerr4), .data_out(dout4)
   );

   // Start at cycle 0; cycle numbers count negedges after the accepting posedge.
   task automatic run3(input logic [47:0] vec, output int dc, output int hs, output int vo,
                       output int vin);
      @(negedge clk);
      din3   = vec;
      start3 = 1'b1;
      @(posedge clk);
      #1 start3 = 1'b0;
      dc = -1; hs = -1; vo = -1; vin = 0;
      for (int c = 1; c < 200; c++) begin
         @(negedge clk);
         if (dut3.isq_valid_in) vin = 1;
         if (dut3.isq_valid_in && dut3.isq_ready_in && hs < 0) hs = c;
         if (dut3.isq_valid_out && vo < 0) vo = c;
         if (done3) begin
            dc = c;
            break;
         end
      end
   endtask

   task automatic run4(input logic [63:0] vec, output int dc);
      @(negedge clk);
      din4   = vec;
      start4 = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
      dc = -1;
      for (int c = 1; c < 200; c++) begin
         @(negedge clk);
         if (done4) begin
            dc = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      checks += 4;
      if (busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy3: got %b want 0", busy3); end
      if (done3 !== 1'b0) begin errors++; $display("FAIL reset_done3: got %b want 0", done3); end
      if (zerr3 !== 1'b0) begin errors++; $display("FAIL reset_zerr3: got %b want 0", zerr3); end
      if (dout3 !== 48'h0) begin errors++; $display("FAIL reset_dout3: got %h want 0", dout3); end
      checks += 2;
      if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4: got %b want 0", busy4); end
      if (dout4 !== 64'h0) begin errors++; $display("FAIL reset_dout4: got %h want 0", dout4); end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (done3 !== 1'b0) begin errors++; $display("FAIL post_reset_done3: got %b want 0", done3); end
   endtask

   task automatic test_unit_x();
      int dc, hs, vo, vin;
      logic [47:0] exp;
      exp = {16'h0000, 16'h0000, 16'h1000};
      run3(exp, dc, hs, vo, vin);
      checks++;
      if (hs < 0 || vo < 0) begin
         errors++;
         $display("FAIL unit_x_isq_seen: hs=%0d vo=%0d want both >= 0", hs, vo);
      end else begin
         lat_l = vo - hs;
      end
      checks++;
      if (hs !== 4) begin errors++; $display("FAIL unit_x_isq_req_cycle: got %0d want 4", hs); end
      checks++;
      if (dc !== 2 * 3 + lat_l + 3) begin
         errors++;
         $display("FAIL unit_x_latency: got %0d want %0d", dc, 2 * 3 + lat_l + 3);
      end
      for (int i = 0; i < 3; i++) begin
         int d;
         d = int'($signed(dout3[i*16 +: 16])) - int'($signed(exp[i*16 +: 16]));
         checks++;
         if (d > 2 || d < -2) begin
            errors++;
            $display("FAIL unit_x_elem%0d: got %h want %h", i, dout3[i*16 +: 16], exp[i*16 +: 16]);
         end
      end
      checks += 2;
      if (zerr3 !== 1'b0) begin errors++; $display("FAIL unit_x_zerr: got %b want 0", zerr3); end
      if (busy3 !== 1'b0) begin errors++; $display("FAIL unit_x_busy_at_done: got %b want 0", busy3); end
      @(negedge clk);
      checks++;
      if (done3 !== 1'b0) begin errors++; $display("FAIL unit_x_done_pulse: got %b want 0", done3); end
   endtask

   task automatic test_vec3(input string name, input logic [47:0] vec, input logic [47:0] exp);
      int dc, hs, vo, vin;
      run3(vec, dc, hs, vo, vin);
      checks++;
      if (dc !== 2 * 3 + lat_l + 3) begin
         errors++;
         $display("FAIL %s_latency: got %0d want %0d", name, dc, 2 * 3 + lat_l + 3);
      end
      for (int i = 0; i < 3; i++) begin
         int d;
         d = int'($signed(dout3[i*16 +: 16])) - int'($signed(exp[i*16 +: 16]));
         checks++;
         if (d > 2 || d < -2) begin
            errors++;
            $display("FAIL %s_elem%0d: got %h want %h", name, i, dout3[i*16 +: 16], exp[i*16 +: 16]);
         end
      end
   endtask

   task automatic test_zero();
      int dc, hs, vo, vin;
      run3(48'h0, dc, hs, vo, vin);
      checks += 4;
      if (dc !== 5) begin errors++; $display("FAIL zero_latency: got %0d want 5", dc); end
      if (zerr3 !== 1'b1) begin errors++; $display("FAIL zero_zerr: got %b want 1", zerr3); end
      if (dout3 !== 48'h0) begin errors++; $display("FAIL zero_dout: got %h want 0", dout3); end
      if (vin !== 0) begin errors++; $display("FAIL zero_isq_valid_in: got %0d want 0", vin); end
      repeat (2) @(negedge clk);
      checks++;
      if (zerr3 !== 1'b1) begin errors++; $display("FAIL zero_zerr_held: got %b want 1", zerr3); end
   endtask

   task automatic test_quat_back_to_back();
      int dc;
      logic [63:0] exp;
      run4({4{16'h1000}}, dc);
      exp = {4{16'h0800}};
      checks++;
      if (dc !== 2 * 4 + lat_l + 3) begin
         errors++;
         $display("FAIL quat1_latency: got %0d want %0d", dc, 2 * 4 + lat_l + 3);
      end
      for (int i = 0; i < 4; i++) begin
         int d;
         d = int'($signed(dout4[i*16 +: 16])) - int'($signed(exp[i*16 +: 16]));
         checks++;
         if (d > 2 || d < -2) begin
            errors++;
            $display("FAIL quat1_elem%0d: got %h want %h", i, dout4[i*16 +: 16], exp[i*16 +: 16]);
         end
      end
      run4({16'h0000, 16'h0000, 16'h0000, 16'h2000}, dc);
      exp = {16'h0000, 16'h0000, 16'h0000, 16'h1000};
      checks++;
      if (dc !== 2 * 4 + lat_l + 3) begin
         errors++;
         $display("FAIL quat2_latency: got %0d want %0d", dc, 2 * 4 + lat_l + 3);
      end
      for (int i = 0; i < 4; i++) begin
         int d;
         d = int'($signed(dout4[i*16 +: 16])) - int'($signed(exp[i*16 +: 16]));
         checks++;
         if (d > 2 || d < -2) begin
            errors++;
            $display("FAIL quat2_elem%0d: got %h want %h", i, dout4[i*16 +: 16], exp[i*16 +: 16]);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      int seen;
      @(negedge clk);
      din3   = {16'hF000, 16'hE000, 16'hE000};
      start3 = 1'b1;
      @(posedge clk);
      #1 start3 = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      #1;
      checks += 3;
      if (busy3 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy3); end
      if (done3 !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done3); end
      if (dout3 !== 48'h0) begin errors++; $display("FAIL midrst_dout: got %h want 0", dout3); end
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      repeat (60) begin
         @(negedge clk);
         if (done3) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL midrst_spurious_done: got %0d want 0", seen); end
      test_vec3("after_rst", {16'h0000, 16'h4000, 16'h3000}, {16'h0000, 16'h0CCD, 16'h099A});
   endtask

   task automatic test_ignored_start();
      int n;
      logic [47:0] got;
      logic [47:0] exp;
      exp = {16'hFAAB, 16'hF555, 16'hF555};
      got = '0;
      n   = 0;
      @(negedge clk);
      din3   = {16'hF000, 16'hE000, 16'hE000};
      start3 = 1'b1;
      @(posedge clk);
      #1 start3 = 1'b0;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (done3) begin
            n++;
            got = dout3;
         end
         if (c == 2 || c == 12) begin
            din3   = {16'h0000, 16'h0000, 16'h1000};
            start3 = 1'b1;
         end else begin
            start3 = 1'b0;
         end
      end
      start3 = 1'b0;
      checks++;
      if (n !== 1) begin errors++; $display("FAIL ignored_start_done_count: got %0d want 1", n); end
      for (int i = 0; i < 3; i++) begin
         int d;
         d = int'($signed(got[i*16 +: 16])) - int'($signed(exp[i*16 +: 16]));
         checks++;
         if (d > 2 || d < -2) begin
            errors++;
            $display("FAIL ignored_start_elem%0d: got %h want %h", i, got[i*16 +: 16], exp[i*16 +: 16]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_unit_x();
      test_vec3("three_four", {16'h0000, 16'h4000, 16'h3000}, {16'h0000, 16'h0CCD, 16'h099A});
      test_vec3("negative", {16'hF000, 16'hE000, 16'hE000}, {16'hFAAB, 16'hF555, 16'hF555});
      test_zero();
      test_quat_back_to_back();
      test_vec3("refill", {16'hF000, 16'hE000, 16'hE000}, {16'hFAAB, 16'hF555, 16'hF555});
      test_reset_mid_op();
      test_ignored_start();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
